vta_mul_engine: RTL

//  Compute engine behind the host-visible control registers. On launch it streams len uint64 pairs from
//  a_addr/b_addr, multiplies each pair and writes the product to c_addr. It then pulses finish, which sets DONE (ctrl bit1).

---
 rtl/vta_mul_pkg.sv | 23 ++
 rtl/vta_mul_pipe.sv | 43 ++++
 rtl/vta_mul_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vta_mul_pkg.sv
// Shared types and default widths for the VTA multiply engine.
// The state enum is shared so that the FSM and any debug readback agree on the encoding.
package vta_mul_pkg;

  localparam int VTA_ADDR_BITS  = 32;
  localparam int VTA_DATA_BITS  = 64;
  localparam int VTA_LEN_BITS   = 32;
  localparam int VTA_MUL_LAT    = 3;
  localparam int VTA_ELEM_BYTES = 8;

  typedef enum logic [3:0] {
    IDLE,
    RD_A_REQ,
    RD_A_DAT,
    RD_B_REQ,
    RD_B_DAT,
    MUL,
    WR,
    WR_ACK,
    DONE
  } state_t;

endpackage

// File: rtl/vta_mul_pipe.sv
// MUL_LAT-stage unsigned multiplier; keeps the low DATA_BITS of the product.
// The valid shift register tracks the single operation in flight.
module vta_mul_pipe
  import vta_mul_pkg::*;
#(
  parameter int DATA_BITS = VTA_DATA_BITS,
  parameter int MUL_LAT   = VTA_MUL_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] prod
);

  logic [MUL_LAT-1:0]   vld;
  logic [DATA_BITS-1:0] stage [MUL_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Data stages need no reset: they are only consumed when the matching valid bit is set.
  always_ff @(posedge clk) begin
    stage[0] <= a * b;
    for (int i = 1; i < MUL_LAT; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign out_valid = vld[MUL_LAT-1];
  assign prod      = stage[MUL_LAT-1];

endmodule

// File: rtl/vta_mul_engine.sv
// Streams len uint64 pairs from a_addr/b_addr, multiplies them and writes products to c_addr.
// Optional busy-cycle counter on ecnt when VTA_MUL_ECNT_EN is defined.
module vta_mul_engine
  import vta_mul_pkg::*;
#(
  parameter int ADDR_BITS = VTA_ADDR_BITS,
  parameter int DATA_BITS = VTA_DATA_BITS,
  parameter int LEN_BITS  = VTA_LEN_BITS,
  parameter int MUL_LAT   = VTA_MUL_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch,
  input  logic [LEN_BITS-1:0]  len,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [ADDR_BITS-1:0] c_addr,
  output logic                 busy,
  output logic                 finish,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [ADDR_BITS-1:0] rd_req_addr,
  input  logic                 rd_data_valid,
  output logic                 rd_data_ready,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_ack,
  output logic [31:0]          ecnt
);

  localparam int OFF_BITS = ADDR_BITS + LEN_BITS;

  state_t               state;
  logic [LEN_BITS-1:0]  idx;
  logic [LEN_BITS-1:0]  idx_next;
  logic [LEN_BITS-1:0]  len_q;
  logic [ADDR_BITS-1:0] a_base;
  logic [ADDR_BITS-1:0] b_base;
  logic [ADDR_BITS-1:0] c_base;
  logic [DATA_BITS-1:0] a_op;
  logic                 mul_start;
  logic                 mul_valid;
  logic [DATA_BITS-1:0] mul_prod;

  // Element address; the sum wraps modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] elem_addr(input logic [ADDR_BITS-1:0] base,
                                                     input logic [LEN_BITS-1:0]  i);
    logic [OFF_BITS-1:0] off;
    off = OFF_BITS'(i) * OFF_BITS'(VTA_ELEM_BYTES);
    return base + off[ADDR_BITS-1:0];
  endfunction

  assign idx_next  = idx + LEN_BITS'(1);
  assign mul_start = (state == RD_B_DAT) && rd_data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      len_q         <= '0;
      a_base        <= '0;
      b_base        <= '0;
      c_base        <= '0;
      a_op          <= '0;
      busy          <= 1'b0;
      finish        <= 1'b0;
      rd_req_valid  <= 1'b0;
      rd_req_addr   <= '0;
      rd_data_ready <= 1'b0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            len_q  <= len;
            a_base <= a_addr;
            b_base <= b_addr;
            c_base <= c_addr;
            idx    <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state        <= RD_A_REQ;
              rd_req_valid <= 1'b1;
              rd_req_addr  <= a_addr;
            end
          end
        end
        RD_A_REQ: begin
          if (rd_req_ready) begin
            rd_req_valid  <= 1'b0;
            rd_data_ready <= 1'b1;
            state         <= RD_A_DAT;
          end
        end
        RD_A_DAT: begin
          if (rd_data_valid) begin
            a_op          <= rd_data;
            rd_data_ready <= 1'b0;
            rd_req_valid  <= 1'b1;
            rd_req_addr   <= elem_addr(b_base, idx);
            state         <= RD_B_REQ;
          end
        end
        RD_B_REQ: begin
          if (rd_req_ready) begin
            rd_req_valid  <= 1'b0;
            rd_data_ready <= 1'b1;
            state         <= RD_B_DAT;
          end
        end
        RD_B_DAT: begin
          // Operand B goes straight into the pipe, so MUL lasts exactly MUL_LAT cycles.
          if (rd_data_valid) begin
            rd_data_ready <= 1'b0;
            state         <= MUL;
          end
        end
        MUL: begin
          if (mul_valid) begin
            wr_valid <= 1'b1;
            wr_addr  <= elem_addr(c_base, idx);
            wr_data  <= mul_prod;
            state    <= WR;
          end
        end
        WR: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= WR_ACK;
          end
        end
        WR_ACK: begin
          if (wr_ack) begin
            if (idx_next == len_q) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              idx          <= idx_next;
              rd_req_valid <= 1'b1;
              rd_req_addr  <= elem_addr(a_base, idx_next);
              state        <= RD_A_REQ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  vta_mul_pipe #(
    .DATA_BITS(DATA_BITS),
    .MUL_LAT  (MUL_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (mul_start),
    .a        (a_op),
    .b        (rd_data),
    .out_valid(mul_valid),
    .prod     (mul_prod)
  );

`ifdef VTA_MUL_ECNT_EN
  logic [31:0] ecnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt_q <= '0;
    end else if (state == IDLE && launch) begin
      ecnt_q <= '0;
    end else if (state != IDLE && ecnt_q != 32'hFFFF_FFFF) begin
      ecnt_q <= ecnt_q + 32'd1;
    end
  end

  assign ecnt = ecnt_q;
`else
  assign ecnt = '0;
`endif

endmodule
